// File: rtl/ctrl_rx_receptionist.sv
// Control-path receptionist: steers UDP payloads whose destination port
// matches the KIP or LAN port to the bridge, and discards everything else.
module ctrl_rx_receptionist #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = 64,
  parameter int IP_ADDRESS_WIDTH = 32,
  parameter int IP_PORT_WIDTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_ap_rst_n,
  input  logic [IP_PORT_WIDTH-1:0]      i_CTRL_KIP_port_number,
  input  logic [IP_PORT_WIDTH-1:0]      i_CTRL_LAN_port_number,
  input  logic                          s_meta_tvalid,
  output logic                          s_meta_tready,
  input  logic [IP_ADDRESS_WIDTH+2*IP_PORT_WIDTH-1:0] s_meta_tdata,
  input  logic                          s_data_tvalid,
  output logic                          s_data_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_data_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]    s_data_tkeep,
  input  logic                          s_data_tlast,
  output logic                          to_bridge_tvalid,
  input  logic                          to_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    to_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]    to_bridge_tkeep,
  output logic                          to_bridge_tlast,
  output logic [IP_PORT_WIDTH-1:0]      to_bridge_tdest,
  output logic [IP_ADDRESS_WIDTH+IP_PORT_WIDTH-1:0] to_bridge_tuser,
  output logic [31:0]                   o_pkt_count,
  output logic [31:0]                   o_drop_count
);

  localparam int IPW = IP_ADDRESS_WIDTH;
  localparam int PW  = IP_PORT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IPW-1:0] r_src_ip;
  logic [PW-1:0]  r_src_port;
  logic [PW-1:0]  r_dst_port;
  logic [31:0]    r_pkt_count;
  logic [31:0]    r_drop_count;

  logic [IPW-1:0] w_ip;
  logic [PW-1:0]  w_sport;
  logic [PW-1:0]  w_dport;
  logic           w_kip_hit;
  logic           w_lan_hit;
  logic           w_match;
  logic           w_meta_hs;
  logic           w_fwd_done;
  logic           w_drop_done;

  assign w_ip    = s_meta_tdata[IPW-1:0];
  assign w_sport = s_meta_tdata[IPW+PW-1:IPW];
  assign w_dport = s_meta_tdata[IPW+2*PW-1:IPW+PW];

  // A zero port number means "disabled", so it must never match.
  assign w_kip_hit = (i_CTRL_KIP_port_number != '0) &&
                     (w_dport == i_CTRL_KIP_port_number);
  assign w_lan_hit = (i_CTRL_LAN_port_number != '0) &&
                     (w_dport == i_CTRL_LAN_port_number);
  assign w_match   = (w_dport != '0) && (w_kip_hit || w_lan_hit);

  assign w_meta_hs   = (r_state == IDLE) && s_meta_tvalid;
  assign w_fwd_done  = (r_state == FWD) && s_data_tvalid &&
                       to_bridge_tready && s_data_tlast;
  assign w_drop_done = (r_state == DROP) && s_data_tvalid &&
                       s_data_tlast;

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (s_meta_tvalid) begin
          w_next = w_match ? FWD : DROP;
        end
      end
      FWD: begin
        if (w_fwd_done) begin
          w_next = IDLE;
        end
      end
      DROP: begin
        if (w_drop_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_src_ip   <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
    end else if (w_meta_hs) begin
      r_src_ip   <= w_ip;
      r_src_port <= w_sport;
      r_dst_port <= w_dport;
    end
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_fwd_done && (r_pkt_count != '1)) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_drop_done && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  // Handshake outputs; reset gates meta ready so nothing is offered
  // while the block is held in reset.
  always_comb begin
    s_meta_tready    = 1'b0;
    s_data_tready    = 1'b0;
    to_bridge_tvalid = 1'b0;
    unique case (r_state)
      IDLE: s_meta_tready = i_ap_rst_n;
      FWD: begin
        to_bridge_tvalid = s_data_tvalid;
        s_data_tready    = to_bridge_tready;
      end
      DROP: s_data_tready = 1'b1;
      default: s_meta_tready = 1'b0;
    endcase
  end

  assign to_bridge_tdata = s_data_tdata;
  assign to_bridge_tkeep = s_data_tkeep;
  assign to_bridge_tlast = s_data_tlast;
  assign to_bridge_tdest = r_dst_port;
  assign to_bridge_tuser = {r_src_port, r_src_ip};

  assign o_pkt_count  = r_pkt_count;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_ctrl_rx_receptionist.sv
// Directed bench for ctrl_rx_receptionist: forward, drop, stall,
// back-to-back and mid-packet reset scenarios.
module tb_ctrl_rx_receptionist;

  logic         clk;
  logic         rst_n;
  logic [15:0]  kip;
  logic [15:0]  lan;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         d_valid;
  logic         d_ready;
  logic [511:0] d_data;
  logic [63:0]  d_keep;
  logic         d_last;
  logic         b_valid;
  logic         b_ready;
  logic [511:0] b_data;
  logic [63:0]  b_keep;
  logic         b_last;
  logic [15:0]  b_dest;
  logic [47:0]  b_user;
  logic [31:0]  pkt_cnt;
  logic [31:0]  drop_cnt;

  int n_vec;
  int n_err;

  ctrl_rx_receptionist dut (
    .i_clk                  (clk),
    .i_ap_rst_n             (rst_n),
    .i_CTRL_KIP_port_number (kip),
    .i_CTRL_LAN_port_number (lan),
    .s_meta_tvalid          (m_valid),
    .s_meta_tready          (m_ready),
    .s_meta_tdata           (m_data),
    .s_data_tvalid          (d_valid),
    .s_data_tready          (d_ready),
    .s_data_tdata           (d_data),
    .s_data_tkeep           (d_keep),
    .s_data_tlast           (d_last),
    .to_bridge_tvalid       (b_valid),
    .to_bridge_tready       (b_ready),
    .to_bridge_tdata        (b_data),
    .to_bridge_tkeep        (b_keep),
    .to_bridge_tlast        (b_last),
    .to_bridge_tdest        (b_dest),
    .to_bridge_tuser        (b_user),
    .o_pkt_count            (pkt_cnt),
    .o_drop_count           (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_meta(input logic [15:0] dst, input logic [15:0] sp,
                           input logic [31:0] ip);
    @(negedge clk);
    m_valid = 1'b1;
    m_data  = {dst, sp, ip};
    #1 chk("meta_rdy", 512'(m_ready), 512'd1);
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  function automatic logic [511:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    kip = 16'hABCD;
    lan = 16'hEFEF;
    m_valid = 1'b0;
    m_data = '0;
    d_valid = 1'b0;
    d_data = '0;
    d_keep = '1;
    d_last = 1'b0;
    b_ready = 1'b0;

    // reset state
    #12;
    chk("rst_meta_rdy", 512'(m_ready), 512'd0);
    chk("rst_bvalid", 512'(b_valid), 512'd0);
    chk("rst_pkt", 512'(pkt_cnt), 512'd0);
    chk("rst_drop", 512'(drop_cnt), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_meta_rdy", 512'(m_ready), 512'd1);
    chk("idle_data_rdy", 512'(d_ready), 512'd0);

    // single-beat KIP packet
    send_meta(16'hABCD, 16'hEFEF, 32'h0A030705);
    d_valid = 1'b1;
    d_data  = pat(32'h1111_0001);
    d_last  = 1'b1;
    b_ready = 1'b1;
    #1;
    chk("s1_valid", 512'(b_valid), 512'd1);
    chk("s1_data", b_data, pat(32'h1111_0001));
    chk("s1_dest", 512'(b_dest), 512'hABCD);
    chk("s1_user", 512'(b_user), 512'hEFEF_0A030705);
    chk("s1_last", 512'(b_last), 512'd1);
    chk("s1_meta_rdy", 512'(m_ready), 512'd0);
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    chk("s1_pkt", 512'(pkt_cnt), 512'd1);
    chk("s1_idle", 512'(m_ready), 512'd1);

    // two-beat LAN packet with a stall on beat 2
    send_meta(16'hEFEF, 16'h0101, 32'hC0A80001);
    d_valid = 1'b1;
    d_data  = pat(32'h2222_0001);
    d_last  = 1'b0;
    b_ready = 1'b1;
    #1;
    chk("s2_b1_data", b_data, pat(32'h2222_0001));
    chk("s2_b1_last", 512'(b_last), 512'd0);
    chk("s2_dest", 512'(b_dest), 512'hEFEF);
    @(negedge clk);
    d_data  = pat(32'h2222_0002);
    d_last  = 1'b1;
    b_ready = 1'b0;
    #1;
    chk("s2_stall_valid", 512'(b_valid), 512'd1);
    chk("s2_stall_drdy", 512'(d_ready), 512'd0);
    @(negedge clk);
    #1;
    chk("s2_hold_data", b_data, pat(32'h2222_0002));
    chk("s2_hold_last", 512'(b_last), 512'd1);
    chk("s2_hold_dest", 512'(b_dest), 512'hEFEF);
    chk("s2_hold_pkt", 512'(pkt_cnt), 512'd1);
    b_ready = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("s2_pkt", 512'(pkt_cnt), 512'd2);

    // three-beat packet to an unknown port is dropped
    send_meta(16'h1234, 16'h0202, 32'h01020304);
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_data = pat(32'h3333_0000 + 32'(i));
      d_last = (i == 2);
      #1;
      chk("s3_drdy", 512'(d_ready), 512'd1);
      chk("s3_bvalid", 512'(b_valid), 512'd0);
      @(negedge clk);
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("s3_drop", 512'(drop_cnt), 512'd1);
    chk("s3_pkt", 512'(pkt_cnt), 512'd2);

    // back-to-back single-beat packets: KIP, LAN, KIP
    @(negedge clk);
    m_valid = 1'b1;
    d_valid = 1'b1;
    d_last  = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] dst;
      dst = (i / 2 == 1) ? 16'hEFEF : 16'hABCD;
      if (i % 2 == 0) m_data = {dst, 16'h0303, 32'h0A000001};
      d_data = pat(32'h4444_0000 + 32'(i));
      #1;
      chk("b2b_valid", 512'(b_valid), 512'(i % 2));
      if (i % 2 == 1) chk("b2b_dest", 512'(b_dest), 512'(dst));
      @(negedge clk);
    end
    m_valid = 1'b0;
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("b2b_pkt", 512'(pkt_cnt), 512'd5);

    // KIP disabled with zero dst port: must drop
    kip = 16'h0000;
    send_meta(16'h0000, 16'h0404, 32'h0B0B0B0B);
    d_valid = 1'b1;
    d_last  = 1'b1;
    #1;
    chk("s5_bvalid", 512'(b_valid), 512'd0);
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("s5_drop", 512'(drop_cnt), 512'd2);

    // equal KIP and LAN ports
    kip = 16'h5555;
    lan = 16'h5555;
    send_meta(16'h5555, 16'h0505, 32'h0C0C0C0C);
    d_valid = 1'b1;
    d_last  = 1'b1;
    #1;
    chk("eq_valid", 512'(b_valid), 512'd1);
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("eq_pkt", 512'(pkt_cnt), 512'd6);

    // port numbers change mid-packet
    kip = 16'hABCD;
    lan = 16'hEFEF;
    send_meta(16'hABCD, 16'h0606, 32'h0D0D0D0D);
    d_valid = 1'b1;
    d_data  = pat(32'h6666_0001);
    @(negedge clk);
    kip    = 16'h0000;
    lan    = 16'h0000;
    d_data = pat(32'h6666_0002);
    d_last = 1'b1;
    #1;
    chk("mid_valid", 512'(b_valid), 512'd1);
    chk("mid_dest", 512'(b_dest), 512'hABCD);
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("mid_pkt", 512'(pkt_cnt), 512'd7);

    // reset during beat 2 of a 4-beat forwarded packet
    kip = 16'hABCD;
    send_meta(16'hABCD, 16'h0707, 32'h0E0E0E0E);
    d_valid = 1'b1;
    d_data  = pat(32'h7777_0001);
    @(negedge clk);
    d_data = pat(32'h7777_0002);
    #1;
    chk("rr_b2_valid", 512'(b_valid), 512'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_bvalid", 512'(b_valid), 512'd0);
    chk("rr_drdy", 512'(d_ready), 512'd0);
    chk("rr_mrdy", 512'(m_ready), 512'd0);
    chk("rr_pkt", 512'(pkt_cnt), 512'd0);
    chk("rr_dest", 512'(b_dest), 512'd0);
    d_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_meta(16'hABCD, 16'h0808, 32'h0F0F0F0F);
    d_valid = 1'b1;
    d_data  = pat(32'h8888_0001);
    d_last  = 1'b1;
    #1;
    chk("rr_new_valid", 512'(b_valid), 512'd1);
    chk("rr_new_dest", 512'(b_dest), 512'hABCD);
    chk("rr_new_user", 512'(b_user), 512'h0808_0F0F0F0F);
    @(negedge clk);
    d_valid = 1'b0;
    d_last  = 1'b0;
    #1;
    chk("rr_new_pkt", 512'(pkt_cnt), 512'd1);
    chk("rr_new_drop", 512'(drop_cnt), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_rx_receptionist.md
CTRL_RX_RECEPTIONIST -- requirements
Module: ctrl_rx_receptionist

Interface
REQ-001 Parameters: AXIS_DATA_WIDTH, 512, data width; AXIS_KEEP_WIDTH, 64, keep width (AXIS_DATA_WIDTH/8); IP_ADDRESS_WIDTH, 32, IPv4 address width; IP_PORT_WIDTH, 16, UDP port width.
REQ-002 Ports, clock and reset first; all handshakes are AXI-Stream tvalid/tready:
- i_clk  in  1  single clock.
- i_ap_rst_n  in  1  reset; asynchronous, active-low.
- i_CTRL_KIP_port_number  in  16  KIP UDP port; 0 disables the match.
- i_CTRL_LAN_port_number  in  16  LAN UDP port; 0 disables the match.
- s_meta_tvalid / s_meta_tready  in / out  1 / 1  per-packet metadata handshake.
- s_meta_tdata  in  64  [31:0] src IP, [47:32] src port, [63:48] dst port.
- s_data_tvalid / s_data_tready  in / out  1 / 1  payload handshake.
- s_data_tdata / s_data_tkeep / s_data_tlast  in  512 / 64 / 1  payload beat.
- to_bridge_tvalid / to_bridge_tready  out / in  1 / 1  output handshake.
- to_bridge_tdata / to_bridge_tkeep / to_bridge_tlast  out  512 / 64 / 1  payload beat.
- to_bridge_tdest  out  16  dst port of the current packet.
- to_bridge_tuser  out  48  [31:0] src IP, [47:32] src port.
- o_pkt_count  out  32  forwarded-packet count, saturating.
- o_drop_count  out  32  dropped-packet count, saturating.

Function
REQ-003 FSM states are IDLE, FWD and DROP.
REQ-004 IDLE: s_meta_tready=1, s_data_tready=0, to_bridge_tvalid=0.
REQ-005 On a metadata handshake in IDLE, the block SHALL register src IP, src port and dst port.
- Next state is FWD when dst port is nonzero and equals a nonzero KIP or LAN port number.
- Otherwise next state is DROP.
- Port numbers are sampled only in that cycle.
REQ-006 FWD: combinational pass-through.
- to_bridge_tvalid=s_data_tvalid; s_data_tready=to_bridge_tready.
- tdata, tkeep and tlast pass through from the input beat.
- tdest and tuser come from the registered metadata, held constant for the whole packet.
REQ-007 FWD: s_meta_tready=0.
REQ-008 FWD: on an output handshake with tlast=1, the block SHALL increment o_pkt_count and return to IDLE.
REQ-009 DROP: s_data_tready=1, to_bridge_tvalid=0, s_meta_tready=0.
REQ-010 DROP: on an input handshake with tlast=1, the block SHALL increment o_drop_count and return to IDLE.
REQ-011 Latency: the first payload beat can appear on the output no earlier than the cycle after the metadata handshake. There is one IDLE cycle between consecutive packets.
REQ-012 A single-beat packet (tlast on the first beat) SHALL be handled as in REQ-008/REQ-010 with no extra cycles.
REQ-013 Output stability: while to_bridge_tvalid=1 and to_bridge_tready=0, tdata, tkeep, tlast, tdest and tuser SHALL be stable, given AXIS-compliant input.
REQ-014 Counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-015 Port-number input changes mid-packet SHALL NOT affect the packet in flight.
REQ-016 The KIP and LAN port numbers may be equal; a match on either forwards the packet.
REQ-017 The block SHALL never accept payload without a preceding metadata handshake, so s_data_tready=0 in IDLE.

Reset
REQ-018 Asserting i_ap_rst_n=0 SHALL immediately force:
- state IDLE;
- all tvalid/tready outputs 0, except s_meta_tready, which becomes 1 after reset deassertion;
- registered metadata, o_pkt_count and o_drop_count to 0.
REQ-019 Reset mid-packet SHALL abandon the packet without counting it; upstream is reset concurrently.
REQ-020 After deassertion, the first accepted metadata SHALL be handled per REQ-005.

Verification
REQ-021 KIP=0xABCD, LAN=0xEFEF; meta {dst 0xABCD, src port 0xEFEF, IP 0x0A030705}; 1 beat, tlast=1 -> one output beat with tdest=0xABCD, tuser=0xEFEF_0A030705; o_pkt_count=1.
REQ-022 Meta dst 0xEFEF; 2-beat packet; tready toggled 1,0,1 -> 2 output beats in order, data held during the stall; tlast only on beat 2; tdest=0xEFEF.
REQ-023 Meta dst 0x1234; 3-beat packet -> no output tvalid; s_data_tready=1 for 3 beats; o_drop_count=1, o_pkt_count unchanged.
REQ-024 Back-to-back: KIP packet, LAN packet, KIP packet, each single-beat, with meta always valid -> 3 outputs with correct tdest, 1 idle cycle between them; o_pkt_count=3.
REQ-025 KIP port set to 0, meta dst 0 -> dropped; o_drop_count increments.
REQ-026 Reset asserted during beat 2 of a 4-beat forwarded packet -> outputs 0 immediately; after release, a new single-beat KIP packet is forwarded correctly; o_pkt_count=1.
